// File: rtl/supermario_pkg.sv
// Shared definitions for the supermario chip command link: mode encodings,
// flag bit positions, frame length and controller state encoding.
package supermario_pkg;

  localparam int unsigned SPI_LEN = 8;
  localparam int unsigned MODE_W  = 3;
  localparam int unsigned FLAG_W  = 5;

  localparam int unsigned FLAG_MIN       = 0;
  localparam int unsigned FLAG_MED       = 1;
  localparam int unsigned FLAG_MAX       = 2;
  localparam int unsigned FLAG_MAD       = 3;
  localparam int unsigned FLAG_DEBUG_MUX = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_CYCLE           = 3'b000,
    MODE_CYCLE_WGAIN     = 3'b001,
    MODE_DOUBLE_SAMPLING = 3'b010,
    MODE_SINGLE_PIXEL    = 3'b011,
    MODE_ADC_RESET       = 3'b110,
    MODE_IDLE            = 3'b111
  } mode_e;

  typedef struct packed {
    mode_e               mode;
    logic [FLAG_W-1:0]   flags;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_WAIT_EOF
  } state_e;

  // Run modes start a frame on the chip that ends with an EoF pulse.
  function automatic logic mode_needs_eof(input mode_e mode);
    return (mode == MODE_CYCLE) || (mode == MODE_CYCLE_WGAIN) ||
           (mode == MODE_DOUBLE_SAMPLING);
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// TX/RX shift registers and bit counter for one MSB-first SPI byte.
module spi_byte_shifter
  import supermario_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [SPI_LEN-1:0] load_data,
  input  logic               shift_en,
  input  logic               rx_bit,
  output logic               tx_bit,
  output logic [SPI_LEN-1:0] rx_byte_c,
  output logic               last_bit_c
);

  localparam int unsigned BIT_CNT_W = $clog2(SPI_LEN);

  logic [SPI_LEN-1:0]   tx_sr;
  logic [SPI_LEN-2:0]   rx_sr;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // TX drains with zero fill so the line idles low once the byte is out.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      tx_sr   <= load_data;
      rx_sr   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      tx_sr   <= {tx_sr[SPI_LEN-2:0], 1'b0};
      rx_sr   <= {rx_sr[SPI_LEN-3:0], rx_bit};
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  assign tx_bit     = tx_sr[SPI_LEN-1];
  assign rx_byte_c  = {rx_sr, rx_bit};
  assign last_bit_c = (bit_cnt == BIT_CNT_W'(SPI_LEN - 1));

endmodule

// File: rtl/spi_cmd_master.sv
// Sends one command byte to the chip, checks the echoed byte against the
// previous command, and waits for end-of-frame after run-mode commands.
module spi_cmd_master
  import supermario_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 262143
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [SPI_LEN-1:0] cmd_data,
  output logic               cmd_ready,
  output logic               CS,
  output logic               SPI_FtoC,
  input  logic               SPI_CtoF,
  input  logic               EoF,
  output logic               echo_valid,
  output logic [SPI_LEN-1:0] echo_data,
  output logic               echo_error,
  output logic               frame_active,
  output logic               timeout
);

  localparam int unsigned CNT_W        = 20;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [SPI_LEN-1:0] expected_q, expected_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               cs_q, cs_d;
  logic               echo_valid_q, echo_valid_d;
  logic [SPI_LEN-1:0] echo_data_q, echo_data_d;
  logic               echo_error_q, echo_error_d;
  logic               frame_active_q, frame_active_d;
  logic               timeout_q, timeout_d;

  logic               load_c;
  logic               shift_en_c;
  logic [SPI_LEN-1:0] rx_byte_c;
  logic               last_bit_c;

  spi_byte_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .load_data  (cmd_data),
    .shift_en   (shift_en_c),
    .rx_bit     (SPI_CtoF),
    .tx_bit     (SPI_FtoC),
    .rx_byte_c  (rx_byte_c),
    .last_bit_c (last_bit_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cmd_q          <= '0;
      expected_q     <= '0;
      cnt_q          <= '0;
      cmd_ready_q    <= 1'b0;
      cs_q           <= 1'b1;
      echo_valid_q   <= 1'b0;
      echo_data_q    <= '0;
      echo_error_q   <= 1'b0;
      frame_active_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      expected_q     <= expected_d;
      cnt_q          <= cnt_d;
      cmd_ready_q    <= cmd_ready_d;
      cs_q           <= cs_d;
      echo_valid_q   <= echo_valid_d;
      echo_data_q    <= echo_data_d;
      echo_error_q   <= echo_error_d;
      frame_active_q <= frame_active_d;
      timeout_q      <= timeout_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    expected_d     = expected_q;
    cnt_d          = cnt_q;
    cmd_ready_d    = 1'b0;
    cs_d           = 1'b1;
    echo_valid_d   = 1'b0;
    echo_data_d    = echo_data_q;
    echo_error_d   = echo_error_q;
    frame_active_d = 1'b0;
    timeout_d      = 1'b0;
    load_c         = 1'b0;
    shift_en_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        // cmd_ready_q is low for the first cycle out of reset.
        if (cmd_valid && cmd_ready_q) begin
          cmd_d       = cmd_t'(cmd_data);
          load_c      = 1'b1;
          cs_d        = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shift_en_c = 1'b1;
        if (last_bit_c) begin
          state_d      = ST_GAP;
          cnt_d        = '0;
          echo_valid_d = 1'b1;
          echo_data_d  = rx_byte_c;
          echo_error_d = (rx_byte_c != expected_q);
          expected_d   = cmd_q;
        end else begin
          cs_d = 1'b0;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (mode_needs_eof(cmd_q.mode)) begin
            state_d        = ST_WAIT_EOF;
            frame_active_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_EOF: begin
        frame_active_d = 1'b1;
        // EoF takes priority over an expiring timeout in the same cycle.
        if (EoF) begin
          state_d        = ST_IDLE;
          frame_active_d = 1'b0;
          cmd_ready_d    = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d        = ST_IDLE;
          frame_active_d = 1'b0;
          cmd_ready_d    = 1'b1;
          timeout_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready    = cmd_ready_q;
  assign CS           = cs_q;
  assign echo_valid   = echo_valid_q;
  assign echo_data    = echo_data_q;
  assign echo_error   = echo_error_q;
  assign frame_active = frame_active_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master: one default instance and one with a
// short EoF timeout, both driven from the same stimulus.
module tb_spi_cmd_master;

  localparam int unsigned GAP_CYCLES = 4;
  localparam int unsigned TO_SHORT   = 50;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       ctof;
  logic       eof;
  logic       sel;

  logic       a_ready, a_cs, a_ftoc, a_ev, a_ee, a_fa, a_to;
  logic [7:0] a_ed;
  logic       b_ready, b_cs, b_ftoc, b_ev, b_ee, b_fa, b_to;
  logic [7:0] b_ed;

  logic       o_ready, o_cs, o_ftoc, o_ev, o_ee, o_fa, o_to;
  logic [7:0] o_ed;

  int checks = 0;
  int errors = 0;

  spi_cmd_master #(.GAP_CYCLES(GAP_CYCLES)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(a_ready), .CS(a_cs), .SPI_FtoC(a_ftoc), .SPI_CtoF(ctof),
    .EoF(eof), .echo_valid(a_ev), .echo_data(a_ed), .echo_error(a_ee),
    .frame_active(a_fa), .timeout(a_to)
  );

  spi_cmd_master #(.GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TO_SHORT)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(b_ready), .CS(b_cs), .SPI_FtoC(b_ftoc), .SPI_CtoF(ctof),
    .EoF(eof), .echo_valid(b_ev), .echo_data(b_ed), .echo_error(b_ee),
    .frame_active(b_fa), .timeout(b_to)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_cs    = sel ? b_cs    : a_cs;
  assign o_ftoc  = sel ? b_ftoc  : a_ftoc;
  assign o_ev    = sel ? b_ev    : a_ev;
  assign o_ed    = sel ? b_ed    : a_ed;
  assign o_ee    = sel ? b_ee    : a_ee;
  assign o_fa    = sel ? b_fa    : a_fa;
  assign o_to    = sel ? b_to    : a_to;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] chip;
    logic       err;
    logic       frame;
    int         eof_dly;
    logic       noise;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  // Offer a command, follow the 8 shift cycles, end on the first GAP cycle.
  task automatic send(input logic [7:0] cmd, input logic [7:0] chip,
                      input logic exp_err, input logic noise);
    int n;
    n = 0;
    eof       = noise;
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    while (o_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 8'(o_ready), 8'h01);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      chk("shift_cs", 8'(o_cs), 8'h00);
      chk("shift_ftoc", 8'(o_ftoc), 8'(cmd[k]));
      chk("shift_ready", 8'(o_ready), 8'h00);
      ctof = chip[k];
      @(negedge clk);
    end
    ctof = 1'b0;
    chk("gap_cs", 8'(o_cs), 8'h01);
    chk("echo_valid", 8'(o_ev), 8'h01);
    chk("echo_data", o_ed, chip);
    chk("echo_error", 8'(o_ee), 8'(exp_err));
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    ctof      = 1'b0;
    eof       = 1'b0;
    sel       = 1'b0;

    // cmd, chip echo, echo_error, enters frame, EoF delay (-1: none), EoF noise
    vecs[0] = '{8'h1F, 8'h00, 1'b0, 1'b1, 100, 1'b0};
    vecs[1] = '{8'h60, 8'h1F, 1'b0, 1'b0, 0,   1'b0};
    vecs[2] = '{8'hC5, 8'hAA, 1'b1, 1'b0, 0,   1'b1};
    vecs[3] = '{8'h41, 8'hC5, 1'b0, 1'b1, 3,   1'b1};
    vecs[4] = '{8'hE0, 8'h00, 1'b1, 1'b0, 0,   1'b0};
    vecs[5] = '{8'h3A, 8'hE0, 1'b0, 1'b1, 0,   1'b0};
    vecs[6] = '{8'h20, 8'h3A, 1'b0, 1'b1, -1,  1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cs", 8'(o_cs), 8'h01);
    chk("rst_ftoc", 8'(o_ftoc), 8'h00);
    chk("rst_ready", 8'(o_ready), 8'h00);
    chk("rst_echo_valid", 8'(o_ev), 8'h00);
    chk("rst_echo_data", o_ed, 8'h00);
    chk("rst_echo_error", 8'(o_ee), 8'h00);
    chk("rst_frame", 8'(o_fa), 8'h00);
    chk("rst_timeout", 8'(o_to), 8'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 8'(o_ready), 8'h01);

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].cmd, vecs[i].chip, vecs[i].err, vecs[i].noise);
      @(negedge clk);
      chk("echo_single_pulse", 8'(o_ev), 8'h00);
      repeat (GAP_CYCLES - 2) @(negedge clk);
      chk("gap_last_cs", 8'(o_cs), 8'h01);
      chk("gap_last_ready", 8'(o_ready), 8'h00);
      chk("gap_last_frame", 8'(o_fa), 8'h00);
      @(negedge clk);
      eof = 1'b0;
      if (vecs[i].frame) begin
        chk("frame_entry", 8'(o_fa), 8'h01);
        chk("frame_ready", 8'(o_ready), 8'h00);
        if (vecs[i].eof_dly >= 0) begin
          repeat (vecs[i].eof_dly) @(negedge clk);
          chk("frame_before_eof", 8'(o_fa), 8'h01);
          eof = 1'b1;
          @(negedge clk);
          eof = 1'b0;
          chk("eof_ready", 8'(o_ready), 8'h01);
          chk("eof_frame", 8'(o_fa), 8'h00);
          chk("eof_timeout", 8'(o_to), 8'h00);
        end
      end else begin
        chk("no_frame_ready", 8'(o_ready), 8'h01);
        chk("no_frame_frame", 8'(o_fa), 8'h00);
      end
    end

    // Command held during a frame waits for EoF, then goes on the first IDLE cycle
    cmd_valid = 1'b1;
    cmd_data  = 8'h7F;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("hold_cs", 8'(o_cs), 8'h01);
      chk("hold_ready", 8'(o_ready), 8'h00);
    end
    eof = 1'b1;
    @(negedge clk);
    eof = 1'b0;
    chk("hold_idle_ready", 8'(o_ready), 8'h01);
    chk("hold_idle_cs", 8'(o_cs), 8'h01);
    send(8'h7F, 8'h20, 1'b0, 1'b0);
    repeat (GAP_CYCLES) @(negedge clk);
    chk("hold_done_ready", 8'(o_ready), 8'h01);
    chk("hold_done_frame", 8'(o_fa), 8'h00);

    // Reset on the 4th shift cycle aborts the byte and clears the expected byte
    cmd_valid = 1'b1;
    cmd_data  = 8'h9C;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_shift_cs", 8'(o_cs), 8'h00);
    repeat (3) @(negedge clk);
    chk("abort_4th_cs", 8'(o_cs), 8'h00);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cs", 8'(o_cs), 8'h01);
    chk("abort_ftoc", 8'(o_ftoc), 8'h00);
    chk("abort_ready", 8'(o_ready), 8'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_rise", 8'(o_ready), 8'h01);
    send(8'h60, 8'h00, 1'b0, 1'b0);
    repeat (GAP_CYCLES) @(negedge clk);
    chk("abort_after_ready", 8'(o_ready), 8'h01);

    // Short-timeout instance
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sel = 1'b1;
    send(8'h20, 8'h00, 1'b0, 1'b0);
    repeat (GAP_CYCLES) @(negedge clk);
    chk("to_frame_entry", 8'(o_fa), 8'h01);
    for (int c = 1; c < int'(TO_SHORT); c++) begin
      @(negedge clk);
      chk("to_waiting", 8'(o_to), 8'h00);
      chk("to_frame_hold", 8'(o_fa), 8'h01);
    end
    @(negedge clk);
    chk("to_pulse", 8'(o_to), 8'h01);
    chk("to_frame_drop", 8'(o_fa), 8'h00);
    chk("to_ready", 8'(o_ready), 8'h01);
    @(negedge clk);
    chk("to_pulse_end", 8'(o_to), 8'h00);

    send(8'h20, 8'h20, 1'b0, 1'b0);
    repeat (GAP_CYCLES) @(negedge clk);
    chk("race_frame_entry", 8'(o_fa), 8'h01);
    repeat (TO_SHORT - 1) @(negedge clk);
    chk("race_frame_last", 8'(o_fa), 8'h01);
    eof = 1'b1;
    @(negedge clk);
    eof = 1'b0;
    chk("race_no_timeout", 8'(o_to), 8'h00);
    chk("race_frame_drop", 8'(o_fa), 8'h00);
    chk("race_ready", 8'(o_ready), 8'h01);
    @(negedge clk);
    chk("race_no_timeout_late", 8'(o_to), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_master.md
SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4: number of CS-high cycles between transactions (minimum 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 262143: maximum cycles spent waiting for EoF.
REQ-003 SHALL have port clk, input, 1 bit: single clock.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a command byte is offered.
REQ-006 SHALL have port cmd_data, input, 8 bits: [7:5] is the chip mode; [4:0] are Min, Med, Max, Mad and debug_mux, in that order from bit 0 (Min) to bit 4 (debug_mux).
REQ-007 SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-008 SHALL have port CS, output, 1 bit: chip select to the chip, active-low.
REQ-009 SHALL have port SPI_FtoC, output, 1 bit: serial data to the chip, MSB first.
REQ-010 SHALL have port SPI_CtoF, input, 1 bit: serial echo from the chip.
REQ-011 SHALL have port EoF, input, 1 bit: end-of-frame pulse from the chip.
REQ-012 SHALL have port echo_valid, output, 1 bit: one-cycle pulse marking echo_data and echo_error as valid.
REQ-013 SHALL have port echo_data, output, 8 bits: byte received during the last transaction.
REQ-014 SHALL have port echo_error, output, 1 bit: echo_data differs from the expected byte.
REQ-015 SHALL have port frame_active, output, 1 bit: a run-mode frame is in progress.
REQ-016 SHALL have port timeout, output, 1 bit: one-cycle pulse when the EoF wait expires.

Function
REQ-017 SHALL implement states IDLE, SHIFT, GAP and WAIT_EOF; all outputs SHALL be registered.
REQ-018 In IDLE, cmd_ready SHALL be 1; cmd_ready SHALL be 0 in every other state.
REQ-019 On the edge where cmd_valid=1 and cmd_ready=1, the block SHALL latch cmd_data, drive CS=0 and SPI_FtoC=cmd_data[7] from that edge, and enter SHIFT.
REQ-020 In SHIFT, CS SHALL stay 0 for exactly 8 cycles, presenting bits 7 down to 0 on SPI_FtoC, one bit per cycle.
REQ-021 In SHIFT, SPI_CtoF SHALL be sampled on each of the 8 edges where CS=0, MSB first; the first sample is bit 7.
REQ-022 After the 8th bit, CS SHALL return to 1 and the block SHALL enter GAP, staying there for GAP_CYCLES cycles.
REQ-023 On GAP entry, echo_valid SHALL pulse for 1 cycle with echo_data equal to the 8 sampled bits.
REQ-024 echo_error SHALL equal (echo_data != expected); after this comparison, expected SHALL be replaced with the byte just sent.
REQ-025 At the end of GAP, the block SHALL enter WAIT_EOF if the sent mode field is 000, 001 or 010; otherwise it SHALL enter IDLE.
REQ-026 In WAIT_EOF, frame_active SHALL be 1, and a 20-bit counter SHALL count from 0.
REQ-027 In WAIT_EOF, EoF=1 SHALL return the block to IDLE on the next edge.
REQ-028 In WAIT_EOF, if the counter reaches TIMEOUT_CYCLES, timeout SHALL pulse for 1 cycle and the block SHALL return to IDLE.
REQ-029 If EoF and the timeout condition occur in the same cycle, EoF SHALL win and timeout SHALL stay 0.
REQ-030 EoF SHALL be ignored in IDLE, SHIFT and GAP.
REQ-031 cmd_valid SHALL be ignored while cmd_ready=0; the offered command SHALL not be lost and SHALL be accepted once cmd_ready=1 if still valid.
REQ-032 The block SHALL NOT start a transaction while frame_active=1, because lowering CS mid-frame clears the chip's flag outputs.

Reset
REQ-033 While reset=1 at a clock edge, the block SHALL set: state=IDLE, CS=1, SPI_FtoC=0, cmd_ready=0, echo_valid=0, echo_data=0x00, echo_error=0, frame_active=0, timeout=0, expected=0x00, counters=0.
REQ-034 cmd_ready SHALL rise on the first edge after reset=0.
REQ-035 Reset asserted during SHIFT SHALL abort the byte, with CS=1 after the next edge.

Structure
REQ-036 A shared package supermario_pkg SHALL hold the mode encodings (CYCLE=000, CYCLE_WGAIN=001, DOUBLE_SAMPLING=010, SINGLE_PIXEL=011, ADC_RESET=110, IDLE=111), the flag bit positions and SPI_LEN=8.
REQ-037 A single sub-module, spi_byte_shifter, SHALL implement the TX/RX shift registers and the 3-bit bit counter.

Verification
REQ-038 Scenario: after reset, send 0x1F -> CS low for exactly 8 cycles; SPI_FtoC reads 0,0,0,1,1,1,1,1; echo_data=0x00; echo_error=0; frame_active=1.
REQ-039 Scenario: with frame_active=1, pulse EoF 100 cycles later, then send 0x60 -> cmd_ready is back 1 cycle after EoF; echo_data=0x1F; echo_error=0; no WAIT_EOF is entered.
REQ-040 Scenario: chip model returns 0xAA when 0x60 is expected -> echo_error=1 and echo_valid=1 in the same cycle.
REQ-041 Scenario: with TIMEOUT_CYCLES=50, send 0x20 and never assert EoF -> timeout pulses once 50 cycles into WAIT_EOF, then IDLE; with EoF in that same cycle instead -> no timeout.
REQ-042 Scenario: assert reset at the 4th SHIFT cycle -> CS=1 next edge; the next echo is compared against 0x00.
REQ-043 Scenario: hold cmd_valid=1 with 0x7F during WAIT_EOF -> no CS activity until EoF; the command is accepted on the first IDLE cycle.
